lzc_seq_scan: RTL and testbench
===============================

LZC_SEQ_SCAN -- requirements
Module: lzc_seq_scan

Interface
REQ-001 SHALL have parameter WORD_W, default 64, giving the width of the per-cycle leading-zero counter; it SHALL be a power of 2 and at least 2.
REQ-002 SHALL have parameter N_WORDS, default 4, giving the number of words per operand; it SHALL be at least 1.
REQ-003 SHALL have derived localparams DATA_W = WORD_W*N_WORDS and CNT_W = $clog2(DATA_W)+1.
REQ-004 SHALL have port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  operand offered.
REQ-007 SHALL have port in_ready  output  1  block can accept an operand.
REQ-008 SHALL have port in_data  input  DATA_W  operand; bit DATA_W-1 is the MSB.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port out_cnt  output  CNT_W  number of leading zeros of the operand.
REQ-012 SHALL have port out_zero  output  1  operand was all zeros.

Function
REQ-013 SHALL contain exactly one combinational WORD_W-bit leading-zero counter (an LZC_classic #(WORD_W) instance or equivalent), time-shared across words.
REQ-014 SHALL implement the FSM states IDLE, SCAN and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in SCAN and DONE, in_ready SHALL be 0.
REQ-016 On an edge where in_valid=1 and in_ready=1, the block SHALL capture in_data, clear the word index and accumulator to 0, and go to SCAN.
REQ-017 in_valid SHALL be ignored outside IDLE.
REQ-018 In SCAN, the word examined in scan cycle i (i=0..N_WORDS-1) SHALL be in_data word N_WORDS-1-i, most significant word first.
REQ-019 In SCAN, if the examined word is nonzero, the block SHALL set out_cnt = acc + lzc(word) and out_zero=0, then go to DONE.
REQ-020 In SCAN, if the examined word is zero and it is not the last word, the block SHALL set acc = acc + WORD_W, increment the index, and stay in SCAN.
REQ-021 In SCAN, if the examined word is zero and it is the last word, the block SHALL set out_cnt = DATA_W and out_zero=1, then go to DONE.
REQ-022 Latency SHALL be k edges from the accept edge to the first cycle with out_valid=1, where k = words examined (1..N_WORDS), giving early termination.
REQ-023 out_cnt arithmetic SHALL be unsigned CNT_W-bit, and the maximum value DATA_W SHALL fit without overflow.
REQ-024 In DONE, out_valid SHALL be 1, and out_cnt and out_zero SHALL hold stable until the handshake completes.
REQ-025 On an edge where out_valid=1 and out_ready=1, the block SHALL go to IDLE, so in_ready=1 in the next cycle (no same-cycle accept; minimum 1 idle cycle between operands).
REQ-026 out_valid SHALL be 0 in IDLE and SCAN.
REQ-027 out_cnt and out_zero SHALL retain their last values in IDLE and SCAN; they are only meaningful when out_valid=1.
REQ-028 With N_WORDS=1, every operand SHALL complete in exactly 1 SCAN cycle.

Reset
REQ-029 While rst=1 at an edge, the block SHALL set state=IDLE, out_valid=0, out_cnt=0, out_zero=0, index=0 and acc=0; in_ready SHALL be 0 while rst is high.
REQ-030 rst asserted in SCAN or DONE SHALL discard the operand or result; no out_valid pulse SHALL follow the release.
REQ-031 In the first cycle after rst deasserts, in_ready SHALL be 1.

Verification (WORD_W=64, N_WORDS=4, DATA_W=256, CNT_W=9)
REQ-032 Bench SHALL drive in_data = 1<<255 -> required: out_cnt=0, out_zero=0, out_valid 1 edge after accept.
REQ-033 Bench SHALL drive in_data = 1<<130 -> required: out_cnt=125 (64+61), out_zero=0, out_valid 2 edges after accept.
REQ-034 Bench SHALL drive in_data = 1 -> required: out_cnt=255, out_valid 4 edges after accept; then in_data = 0 -> required: out_cnt=256, out_zero=1, 4 edges.
REQ-035 Bench SHALL hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new data -> required: outputs stable, in_ready=0, new data not captured; out_ready=1 -> IDLE next cycle.
REQ-036 Bench SHALL assert rst for 1 cycle during scan cycle 2 of in_data=1 -> required: out_valid stays 0, in_ready=1 after release, next operand 1<<200 gives out_cnt=55.
REQ-037 Bench SHALL check every result against a reference loop over all walking-one and walking-zero patterns plus random operands, using the shift sequence A = {A[254:0], ~A[0]} from A=0.

Source files
------------

// File: rtl/lzc_seq_scan.sv
// Sequential leading-zero counter: scans a wide operand one word per cycle, MSW first,
// with a single time-shared word-level LZC and early exit on the first nonzero word.
module lzc_seq_scan #(
   parameter int unsigned WORD_W  = 64,
   parameter int unsigned N_WORDS = 4,
   localparam int unsigned DATA_W = WORD_W * N_WORDS,
   localparam int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_cnt,
   output logic              out_zero
);

   localparam int unsigned LZ_W  = $clog2(WORD_W) + 1;
   localparam int unsigned IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                zero_q, zero_d;

   logic [WORD_W-1:0]   word;
   logic [LZ_W-1:0]     word_lz;

   // The operand register shifts left each zero word, so the word under test is always the top one.
   assign word = data_q[DATA_W-1 -: WORD_W];

   always_comb begin
      word_lz = LZ_W'(WORD_W);
      for (int unsigned i = 0; i < WORD_W; i++) begin
         if (word[i]) word_lz = LZ_W'(WORD_W - 1 - i);
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               data_d  = in_data;
               idx_d   = '0;
               acc_d   = '0;
               state_d = StScan;
            end
         end
         StScan: begin
            if (|word) begin
               cnt_d   = acc_q + CNT_W'(word_lz);
               zero_d  = 1'b0;
               state_d = StDone;
            end else if (idx_q == LAST_IDX) begin
               cnt_d   = CNT_W'(DATA_W);
               zero_d  = 1'b1;
               state_d = StDone;
            end else begin
               acc_d  = acc_q + CNT_W'(WORD_W);
               idx_d  = idx_q + 1'b1;
               data_d = data_q << WORD_W;
            end
         end
         StDone: begin
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         data_q  <= '0;
         idx_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
      end
   end

   assign in_ready  = (state_q == StIdle) && !rst;
   assign out_valid = (state_q == StDone);
   assign out_cnt   = cnt_q;
   assign out_zero  = zero_q;

endmodule

// File: tb/tb_lzc_seq_scan.sv
// Scoreboard bench for lzc_seq_scan: the driver queues expected results, a negedge monitor
// checks latency, hold stability and values of every result presented.
module tb_lzc_seq_scan;

   localparam int unsigned WORD_W  = 64;
   localparam int unsigned N_WORDS = 4;
   localparam int unsigned DATA_W  = 256;
   localparam int unsigned CNT_W   = 9;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CNT_W-1:0]  out_cnt;
   logic              out_zero;

   typedef struct {
      int cnt;
      int zero;
      int lat;
      int acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   lzc_seq_scan #(
      .WORD_W (WORD_W),
      .N_WORDS(N_WORDS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_cnt  (out_cnt),
      .out_zero (out_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: latency on first valid cycle, stability while held, values on handshake.
   initial begin : monitor
      logic       seen;
      int         held_cnt;
      int         held_zero;
      exp_t       e;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid) begin
            if (!seen) begin
               seen      = 1'b1;
               held_cnt  = int'(out_cnt);
               held_zero = int'(out_zero);
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_valid: got out_valid=1 expected 0 (cycle %0d)", cyc);
               end else begin
                  chk("latency", cyc - sb[0].acc, sb[0].lat);
               end
            end else begin
               chk("hold_cnt", int'(out_cnt), held_cnt);
               chk("hold_zero", int'(out_zero), held_zero);
            end
            if (out_ready) begin
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("out_cnt", int'(out_cnt), e.cnt);
                  chk("out_zero", int'(out_zero), e.zero);
               end
               seen = 1'b0;
            end
         end
      end
   end

   task automatic ref_model(input logic [DATA_W-1:0] a, output int cnt, output int zero,
                            output int lat);
      cnt = DATA_W;
      for (int i = 0; i < int'(DATA_W); i++) begin
         if (a[i]) cnt = DATA_W - 1 - i;
      end
      zero = (a == '0) ? 1 : 0;
      lat  = zero ? N_WORDS : (cnt / WORD_W) + 1;
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input int cnt, input int zero, input int lat);
      int   n;
      exp_t e;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = d;
      n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 (cycle %0d)", cyc);
         in_valid = 1'b0;
         return;
      end
      e.cnt  = cnt;
      e.zero = zero;
      e.lat  = lat;
      e.acc  = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_ref(input logic [DATA_W-1:0] d);
      int c, z, l;
      ref_model(d, c, z, l);
      send(d, c, z, l);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin : stim
      logic [DATA_W-1:0] one;
      logic [DATA_W-1:0] a;
      int n;
      one       = 1;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_cnt", int'(out_cnt), 0);
      chk("rst_out_zero", int'(out_zero), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", int'(in_ready), 1);

      // Directed vectors, hand-computed.
      send(one << 255, 0, 0, 1);
      send(one << 130, 125, 0, 2);
      send(one, 255, 0, 4);
      send('0, 256, 1, 4);
      drain();

      // Stall in DONE while offering new data.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(one << 100, 155, 0, 3);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("stall_reach_done", int'(out_valid), 1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = {8{$urandom()}};
         #1;
         chk("stall_in_ready", int'(in_ready), 0);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_idle_in_ready", int'(in_ready), 1);
      chk("stall_idle_out_valid", int'(out_valid), 0);
      drain();
      repeat (3) @(posedge clk);
      chk("stall_no_capture", sb.size(), 0);

      // Reset during scan cycle 2 of in_data=1: result must be discarded.
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = one;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("scan_rst_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("scan_rst_release_ready", int'(in_ready), 1);
      repeat (6) @(posedge clk);
      send(one << 200, 55, 0, 1);
      drain();

      // Reference sweep: walking one, walking zero, shift sequence, random.
      for (int i = 0; i < int'(DATA_W); i++) send_ref(one << i);
      for (int i = 0; i < int'(DATA_W); i++) send_ref(~(one << i));
      a = '0;
      for (int i = 0; i < 300; i++) begin
         send_ref(a);
         a = {a[DATA_W-2:0], ~a[0]};
      end
      for (int i = 0; i < 40; i++) begin
         for (int w = 0; w < int'(N_WORDS); w++) begin
            a[w*WORD_W +: WORD_W] = ($urandom_range(0, 1) == 1) ? '0 : {$urandom(), $urandom()};
         end
         send_ref(a);
      end
      drain();

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
